dtc_trig_decoder_v2: RTL and testbench
======================================

DTC_TRIG_DECODER_V2 -- requirements
Module: dtc_trig_decoder_v2

Interface
REQ-001 SHALL have parameter CODE_W, 2: number of trigger-code bits following the start bit (1..6).
REQ-002 SHALL have parameter L1_LAT_MAX, 256: L1 acceptance window after L0, in dtc_clk cycles (2..65535).
REQ-003 SHALL have parameter CNT_W, 16: width of each statistics counter.
REQ-004 SHALL have port dtc_clk  input  1  sole clock; every register is clocked on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port trig_in  input  1  sampled DTC trigger line (IDDR Q1, rising-edge sample); idle level 0.
REQ-007 SHALL have port enable  input  1  1 = decode; 0 = FSM held in IDLE and the window closed.
REQ-008 SHALL have port clr_cnt  input  1  synchronous clear of all three counters.
REQ-009 SHALL have port trig_l0  output  1  one-cycle pulse per accepted L0.
REQ-010 SHALL have port trig_l1  output  1  one-cycle pulse per accepted L1.
REQ-011 SHALL have port trig_code  output  CODE_W  code of the last decoded frame; held until the next decode.
REQ-012 SHALL have port l1_timeout  output  1  one-cycle pulse when the L1 window expires without an L1.
REQ-013 SHALL have port busy  output  1  high while the L1 window is open.
REQ-014 SHALL have ports l0_cnt, l1_cnt, err_cnt  output  CNT_W each  saturating counts of accepted L0, accepted L1 and protocol errors.

Function
REQ-015 SHALL decode frames: a start bit of 1, then CODE_W code bits, MSB first, one bit per cycle.
REQ-016 SHALL use FSM states IDLE, SHIFT and DECODE: IDLE->SHIFT on trig_in=1; SHIFT->DECODE after CODE_W bits; DECODE->IDLE unconditionally.
REQ-017 SHALL ignore trig_in during DECODE (guard bit), so the minimum frame spacing is CODE_W+2 cycles.
REQ-018 SHALL register results: for a start bit sampled in cycle t, the pulse and trig_code update occur in cycle t+CODE_W+1.
REQ-019 SHALL classify code==0 as an L0 frame and code!=0 as an L1 frame whose type is the code value; with CODE_W=1 this reproduces the v1 "10"=L0, "11"=L1 encoding.
REQ-020 SHALL accept an L0 only while the window is closed: pulse trig_l0, increment l0_cnt, open the window and load the window counter with L1_LAT_MAX.
REQ-021 SHALL reject an L0 decoded while the window is open: no trig_l0, window unchanged, increment err_cnt.
REQ-022 SHALL accept an L1 decoded while the window is open: pulse trig_l1, increment l1_cnt, close the window.
REQ-023 SHALL reject an L1 decoded while the window is closed: no trig_l1, increment err_cnt.
REQ-024 SHALL decrement the window counter once per cycle while the window is open; on reaching 0 it closes the window and pulses l1_timeout.
REQ-025 SHALL give L1 priority when the L1 decode and window expiry fall in the same cycle: L1 accepted, no l1_timeout.
REQ-026 SHALL saturate counters at 2^CNT_W-1 with no wrap.
REQ-027 SHALL give clr_cnt priority over a simultaneous increment: the result is 0.
REQ-028 SHALL, when enable is deasserted mid-frame, return the FSM to IDLE next cycle, discard the partial frame, close the window with no l1_timeout and leave counters unchanged.
REQ-029 SHALL update trig_code on every decode, including rejected frames.

Reset
REQ-030 SHALL, with rst_n=0 at a rising edge, set the FSM to IDLE, close the window and clear the window counter.
REQ-031 SHALL drive to 0 during reset: trig_l0, trig_l1, l1_timeout, busy, trig_code, l0_cnt, l1_cnt and err_cnt.
REQ-032 SHALL discard a frame in progress at reset; the first cycle after reset release is IDLE.

Structure
REQ-033 SHALL define the FSM state enum (IDLE/SHIFT/DECODE) and the default CODE_W, L1_LAT_MAX and CNT_W constants in shared package dtc_pkg.
REQ-034 SHALL implement the three counters with one sub-module, dtc_sat_counter (CNT_W; inc, clr, saturation).
REQ-035 SHALL keep the IDDR/ODDR primitives outside this block; it contains no vendor primitives.

Verification (CODE_W=2, L1_LAT_MAX=8, CNT_W=4)
REQ-036 SHALL cover: trig_in 1,0,0 from cycle 10 -> trig_l0 at cycle 13, busy=1, l0_cnt=1.
REQ-037 SHALL cover: L0, then frame 1,1,0 starting 3 cycles later -> trig_l1 pulse, trig_code=2, busy=0, l1_cnt=1, no l1_timeout.
REQ-038 SHALL cover: L0 alone -> l1_timeout exactly 8 cycles after trig_l0, busy falls; then an L1 frame -> no trig_l1, err_cnt=1.
REQ-039 SHALL cover: L1 decode in the expiry cycle -> trig_l1=1, l1_timeout=0.
REQ-040 SHALL cover: 20 L0/L1 pairs -> l0_cnt=l1_cnt=15 (saturated); clr_cnt together with an increment -> 0.
REQ-041 SHALL cover: rst_n=0 or enable=0 after the start bit -> no pulse, FSM IDLE, counters per REQ-028/REQ-031.

Source files
------------

// File: rtl/dtc_pkg.sv
// dtc_pkg -- shared definitions for the DTC trigger decoder.
//   dtc_state_e      : decoder FSM state (IDLE, SHIFT, DECODE)
//   DTC_CODE_W       : default number of code bits after the start bit
//   DTC_L1_LAT_MAX   : default L1 acceptance window, in dtc_clk cycles
//   DTC_CNT_W        : default statistics counter width
//   dtc_win_w()      : width needed to hold a window count of 0..lat
package dtc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DECODE = 2'd2
  } dtc_state_e;

  localparam int DTC_CODE_W     = 2;
  localparam int DTC_L1_LAT_MAX = 256;
  localparam int DTC_CNT_W      = 16;

  function automatic int dtc_win_w(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/dtc_sat_counter.sv
// dtc_sat_counter -- saturating event counter.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset, clears count
//   inc   : add one this cycle (ignored once count is all ones)
//   clr   : synchronous clear, wins over inc
//   count : current value
module dtc_sat_counter
  import dtc_pkg::*;
#(
  parameter int W = DTC_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/dtc_trig_decoder_v2.sv
// dtc_trig_decoder_v2 -- serial DTC trigger frame decoder with L0/L1 window.
//   dtc_clk     : sole clock, rising edge
//   rst_n       : synchronous active-low reset
//   trig_in     : sampled trigger line, idle 0; frame = 1 start bit + CODE_W code bits, MSB first
//   enable      : 1 = decode; 0 = FSM forced to IDLE and the L1 window closed
//   clr_cnt     : synchronous clear of all statistics counters
//   trig_l0     : one-cycle strobe per accepted L0 (code == 0, window closed)
//   trig_l1     : one-cycle strobe per accepted L1 (code != 0, window open)
//   trig_code   : code of the most recently decoded frame, accepted or not
//   l1_timeout  : one-cycle strobe when the window expires without an L1
//   busy        : L1 window open
//   l0_cnt, l1_cnt, err_cnt : saturating statistics
//   fsm_state   : decoder FSM state, for observation only
// There is no valid/ready handshake: every output strobe is a single-cycle
// pulse that downstream logic must capture in the cycle it is high.
module dtc_trig_decoder_v2
  import dtc_pkg::*;
#(
  parameter int CODE_W     = DTC_CODE_W,
  parameter int L1_LAT_MAX = 8'd0 + DTC_L1_LAT_MAX,
  parameter int CNT_W      = DTC_CNT_W
) (
  input  logic              dtc_clk,
  input  logic              rst_n,
  input  logic              trig_in,
  input  logic              enable,
  input  logic              clr_cnt,
  output logic              trig_l0,
  output logic              trig_l1,
  output logic [CODE_W-1:0] trig_code,
  output logic              l1_timeout,
  output logic              busy,
  output logic [CNT_W-1:0]  l0_cnt,
  output logic [CNT_W-1:0]  l1_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output dtc_state_e        fsm_state
);

  localparam int WIN_W = dtc_win_w(L1_LAT_MAX);
  localparam int BIT_W = $clog2(CODE_W + 1);

  dtc_state_e        state;
  logic [BIT_W-1:0]  bit_idx;
  logic [CODE_W-1:0] shreg;
  logic              win_open;
  logic [WIN_W-1:0]  win_cnt;

  logic [CODE_W-1:0] code_next;
  logic              frame_done;
  logic              is_l0;
  logic              l0_acc;
  logic              l1_acc;
  logic              err_ev;
  logic              expire;

  // Decode is resolved on the edge that samples the last code bit, so the
  // result registers land one cycle after that bit and the DECODE state
  // acts as the guard bit that ignores trig_in.
  always_comb begin
    code_next  = (shreg << 1) | CODE_W'(trig_in);
    frame_done = enable && (state == SHIFT) && (bit_idx == BIT_W'(CODE_W - 1));
    is_l0      = (code_next == '0);
    l0_acc     = frame_done && is_l0 && !win_open;
    l1_acc     = frame_done && !is_l0 && win_open;
    err_ev     = frame_done && (is_l0 ? win_open : !win_open);
    // An L1 landing in the expiry cycle takes priority over the timeout.
    expire     = enable && win_open && (win_cnt == WIN_W'(1)) && !l1_acc;
  end

  always_ff @(posedge dtc_clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_idx    <= '0;
      shreg      <= '0;
      win_open   <= 1'b0;
      win_cnt    <= '0;
      trig_l0    <= 1'b0;
      trig_l1    <= 1'b0;
      l1_timeout <= 1'b0;
      trig_code  <= '0;
    end else begin
      trig_l0    <= l0_acc;
      trig_l1    <= l1_acc;
      l1_timeout <= expire;
      if (frame_done) begin
        trig_code <= code_next;
      end

      if (!enable) begin
        // Partial frame dropped, window closed silently.
        state    <= IDLE;
        bit_idx  <= '0;
        shreg    <= '0;
        win_open <= 1'b0;
        win_cnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (trig_in) begin
              state   <= SHIFT;
              bit_idx <= '0;
              shreg   <= '0;
            end
          end
          SHIFT: begin
            shreg   <= code_next;
            bit_idx <= bit_idx + BIT_W'(1);
            if (frame_done) begin
              state <= DECODE;
            end
          end
          DECODE: state <= IDLE;
          default: state <= IDLE;
        endcase

        // A rejected L0 leaves the window counting down untouched.
        if (l0_acc) begin
          win_open <= 1'b1;
          win_cnt  <= WIN_W'(L1_LAT_MAX);
        end else if (l1_acc || expire) begin
          win_open <= 1'b0;
          win_cnt  <= '0;
        end else if (win_open) begin
          win_cnt <= win_cnt - WIN_W'(1);
        end
      end
    end
  end

  assign busy      = win_open;
  assign fsm_state = state;

  dtc_sat_counter #(.W(CNT_W)) u_l0_cnt (
    .clk   (dtc_clk),
    .rst_n (rst_n),
    .inc   (l0_acc),
    .clr   (clr_cnt),
    .count (l0_cnt)
  );

  dtc_sat_counter #(.W(CNT_W)) u_l1_cnt (
    .clk   (dtc_clk),
    .rst_n (rst_n),
    .inc   (l1_acc),
    .clr   (clr_cnt),
    .count (l1_cnt)
  );

  dtc_sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (dtc_clk),
    .rst_n (rst_n),
    .inc   (err_ev),
    .clr   (clr_cnt),
    .count (err_cnt)
  );

endmodule

// File: tb/tb_dtc_trig_decoder_v2.sv
// tb_dtc_trig_decoder_v2 -- bench for dtc_trig_decoder_v2 (CODE_W=2,
// L1_LAT_MAX=8, CNT_W=4). The whole input program is laid out in per-cycle
// arrays up front; a frame-level model turns it into expected strobe events,
// an expected busy trace and spot checks, which a negedge monitor consumes.
module tb_dtc_trig_decoder_v2;
  import dtc_pkg::*;

  localparam int CODE_W     = 2;
  localparam int L1_LAT_MAX = 8;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;
  localparam int MAXC       = 4000;

  // ---------------- clock / reset / DUT ----------------
  logic              dtc_clk = 1'b0;
  logic              rst_n   = 1'b0;
  logic              trig_in = 1'b0;
  logic              enable  = 1'b1;
  logic              clr_cnt = 1'b0;
  logic              trig_l0;
  logic              trig_l1;
  logic [CODE_W-1:0] trig_code;
  logic              l1_timeout;
  logic              busy;
  logic [CNT_W-1:0]  l0_cnt;
  logic [CNT_W-1:0]  l1_cnt;
  logic [CNT_W-1:0]  err_cnt;
  dtc_state_e        fsm_state;

  always #5 dtc_clk = ~dtc_clk;

  dtc_trig_decoder_v2 #(
    .CODE_W     (CODE_W),
    .L1_LAT_MAX (L1_LAT_MAX),
    .CNT_W      (CNT_W)
  ) dut (
    .dtc_clk    (dtc_clk),
    .rst_n      (rst_n),
    .trig_in    (trig_in),
    .enable     (enable),
    .clr_cnt    (clr_cnt),
    .trig_l0    (trig_l0),
    .trig_l1    (trig_l1),
    .trig_code  (trig_code),
    .l1_timeout (l1_timeout),
    .busy       (busy),
    .l0_cnt     (l0_cnt),
    .l1_cnt     (l1_cnt),
    .err_cnt    (err_cnt),
    .fsm_state  (fsm_state)
  );

  // ---------------- program and model state ----------------
  bit line_trig[MAXC];
  bit line_en[MAXC];
  bit line_clr[MAXC];
  bit line_rst[MAXC];
  bit busy_exp[MAXC];

  typedef struct {
    int cyc;
    bit l0;
    bit l1;
    bit to;
    int code;
    int l0c;
    int l1c;
    int errc;
  } ev_t;

  ev_t exp_q[$];
  ev_t spot_q[$];

  bit m_win;
  int m_open_at, m_deadline;
  int m_l0c, m_l1c, m_errc, m_code;

  int cyc  = 0;
  int ncyc = 0;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  function automatic ev_t mk_ev(input int c, input bit l0, input bit l1, input bit to);
    ev_t e;
    e.cyc = c; e.l0 = l0; e.l1 = l1; e.to = to;
    e.code = m_code; e.l0c = m_l0c; e.l1c = m_l1c; e.errc = m_errc;
    return e;
  endfunction

  // Window open from m_open_at up to (not including) cycle c.
  function automatic void close_win(input int c);
    for (int i = m_open_at; i < c; i++) busy_exp[i] = 1'b1;
    m_win = 1'b0;
  endfunction

  function automatic void expire_upto(input int limit);
    if (m_win && (m_deadline <= limit)) begin
      close_win(m_deadline);
      exp_q.push_back(mk_ev(m_deadline, 1'b0, 1'b0, 1'b1));
    end
  endfunction

  function automatic void put_bits(input int s, input int code);
    line_trig[s] = 1'b1;
    for (int b = 0; b < CODE_W; b++) line_trig[s + 1 + b] = ((code >> (CODE_W - 1 - b)) & 1) != 0;
  endfunction

  // Frame whose start bit is driven in cycle s; its result shows in s+CODE_W+1.
  function automatic void add_frame(input int s, input int code, input bit clr);
    int d;
    bit l0a, l1a, to;
    d = s + CODE_W + 1;
    put_bits(s, code);
    if (clr) line_clr[d - 1] = 1'b1;
    expire_upto(d - 1);
    m_code = code;
    l0a = (code == 0) && !m_win;
    l1a = (code != 0) && m_win;
    to  = 1'b0;
    if (l0a)      m_l0c  = sat(m_l0c);
    else if (l1a) m_l1c  = sat(m_l1c);
    else          m_errc = sat(m_errc);
    if (clr) begin m_l0c = 0; m_l1c = 0; m_errc = 0; end
    if (l0a) begin
      m_win = 1'b1; m_open_at = d; m_deadline = d + L1_LAT_MAX;
    end else if (l1a) begin
      close_win(d);
    end else if (m_win && (m_deadline == d)) begin
      close_win(d);
      to = 1'b1;
    end
    if (l0a || l1a || to) exp_q.push_back(mk_ev(d, l0a, l1a, to));
  endfunction

  function automatic void add_disable(input int e);
    line_en[e] = 1'b0;
    expire_upto(e);
    if (m_win) close_win(e + 1);
    spot_q.push_back(mk_ev(e + 1, 1'b0, 1'b0, 1'b0));
  endfunction

  function automatic void add_reset(input int r);
    line_rst[r] = 1'b0;
    expire_upto(r);
    if (m_win) close_win(r + 1);
    m_l0c = 0; m_l1c = 0; m_errc = 0; m_code = 0;
    spot_q.push_back(mk_ev(r + 1, 1'b0, 1'b0, 1'b0));
  endfunction

  function automatic void build();
    int s;
    for (int i = 0; i < MAXC; i++) begin
      line_en[i] = 1'b1; line_rst[i] = 1'b1;
    end
    m_win = 1'b0; m_open_at = 0; m_deadline = 0;
    m_l0c = 0; m_l1c = 0; m_errc = 0; m_code = 0;
    for (int i = 0; i < 3; i++) line_rst[i] = 1'b0;
    add_reset(3);
    // L0 at 10 -> strobe 13; L1 code 2; lone L0 timing out; late L1 error;
    // L1 landing in the expiry cycle.
    add_frame(10, 0, 1'b0);
    add_frame(16, 2, 1'b0);
    add_frame(22, 0, 1'b0);
    add_frame(36, 1, 1'b0);
    add_frame(42, 0, 1'b0);
    add_frame(50, 3, 1'b0);
    // 20 L0/L1 pairs to saturate counters.
    s = 60;
    for (int i = 0; i < 20; i++) begin
      add_frame(s, 0, 1'b0);
      add_frame(s + 4, int'($urandom_range(1, 3)), 1'b0);
      s += 8;
    end
    // Random frames at random spacing.
    for (int i = 0; i < 120; i++) begin
      add_frame(s, int'($urandom_range(0, 3)), 1'b0);
      s += CODE_W + 2 + int'($urandom_range(0, 10));
    end
    // Clear coinciding with an accepted L0, then count from zero.
    s += 16;
    add_frame(s, 0, 1'b1);
    add_frame(s + 4, 1, 1'b0);
    // Enable dropped right after a start bit while the window is open.
    s += 16;
    add_frame(s, 0, 1'b0);
    put_bits(s + 4, 2);
    add_disable(s + 5);
    // Reset right after a start bit while the window is open.
    s += 20;
    add_frame(s, 0, 1'b0);
    put_bits(s + 6, 0);
    add_reset(s + 7);
    add_frame(s + 20, 0, 1'b0);
    ncyc = s + 20 + CODE_W + 1 + L1_LAT_MAX + 10;
    expire_upto(ncyc - 2);
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input int k);
    trig_in = line_trig[k];
    enable  = line_en[k];
    clr_cnt = line_clr[k];
    rst_n   = line_rst[k];
  endtask

  initial begin
    build();
    cyc = 0;
    drive(0);
    while (cyc < ncyc) begin
      @(posedge dtc_clk);
      cyc++;
      #1;
      drive(cyc);
    end
    chk("leftover_events", 32'(exp_q.size()), 32'd0);
    chk("leftover_spots", 32'(spot_q.size()), 32'd0);
    chk("final_l0_cnt", 32'(l0_cnt), 32'(m_l0c));
    chk("final_l1_cnt", 32'(l1_cnt), 32'(m_l1c));
    chk("final_err_cnt", 32'(err_cnt), 32'(m_errc));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge dtc_clk) begin : mon
    ev_t ev;
    if (cyc >= 1 && cyc < ncyc) begin
      chk("busy", 32'(busy), 32'(busy_exp[cyc]));
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        ev = exp_q.pop_front();
        chk("missing_event_cycle", 32'(cyc), 32'(ev.cyc));
      end
      if (trig_l0 === 1'b1 || trig_l1 === 1'b1 || l1_timeout === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {29'd0, trig_l0, trig_l1, l1_timeout}, 32'd0);
        end else begin
          ev = exp_q.pop_front();
          chk("event_cycle", 32'(cyc), 32'(ev.cyc));
          chk("trig_l0", 32'(trig_l0), 32'(ev.l0));
          chk("trig_l1", 32'(trig_l1), 32'(ev.l1));
          chk("l1_timeout", 32'(l1_timeout), 32'(ev.to));
          chk("trig_code", 32'(trig_code), 32'(ev.code));
          chk("l0_cnt", 32'(l0_cnt), 32'(ev.l0c));
          chk("l1_cnt", 32'(l1_cnt), 32'(ev.l1c));
          chk("err_cnt", 32'(err_cnt), 32'(ev.errc));
        end
      end
      while (spot_q.size() > 0 && spot_q[0].cyc < cyc) begin
        ev = spot_q.pop_front();
        chk("missed_spot_cycle", 32'(cyc), 32'(ev.cyc));
      end
      if (spot_q.size() > 0 && spot_q[0].cyc == cyc) begin
        ev = spot_q.pop_front();
        chk("spot_fsm_idle", 32'(fsm_state), 32'(IDLE));
        chk("spot_trig_code", 32'(trig_code), 32'(ev.code));
        chk("spot_l0_cnt", 32'(l0_cnt), 32'(ev.l0c));
        chk("spot_l1_cnt", 32'(l1_cnt), 32'(ev.l1c));
        chk("spot_err_cnt", 32'(err_cnt), 32'(ev.errc));
        chk("spot_strobes", {29'd0, trig_l0, trig_l1, l1_timeout}, 32'd0);
      end
    end
  end

endmodule
